// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch with a small prefetch FIFO.
//
// Issues at most one word-address read per cycle to a synchronous instruction
// memory (one-cycle read latency), captures each returned word together with
// its PC in a DEPTH-entry FIFO, and presents the FIFO head to decode over a
// valid/ready handshake. A redirect flushes everything queued or in flight
// and fetches the new target in the same cycle.
//
// Ports:
//   clk, sync_rst     clock; synchronous active-high reset (overrides clk_en)
//   clk_en            global stall: 0 freezes all state (memory holds too)
//   redirect          redirect fetch to redirect_pc, flush FIFO and in-flight
//   redirect_pc       redirect target word address
//   imem_req          read request this cycle
//   imem_addr         request word address
//   imem_rdata        read data, valid the cycle after an accepted request
//   out_valid         FIFO head valid toward decode
//   out_ready         decode accepts the head
//   out_pc, out_instr word address and instruction at the FIFO head
module fetch_unit #(
  parameter int                 ADDR_W       = 30,
  parameter int                 INSTR_W      = 32,
  parameter int                 DEPTH        = 2,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               sync_rst,
  input  logic               clk_en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic [ADDR_W-1:0]  entry_pc    [DEPTH];
  logic [INSTR_W-1:0] entry_instr [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic             credit_ok;
  logic [CNT_W:0]   occupancy;

  assign imem_addr = redirect ? redirect_pc : fetch_pc_reg;
  assign out_valid = (count_reg != '0) && !redirect && !sync_rst;
  assign pop       = out_valid && out_ready && clk_en;
  // A returning word is only kept when no redirect is flushing it away.
  assign push      = inflight_reg && !redirect;

  // Credit check: entries held + the word still in flight, less the entry
  // leaving this cycle, must leave room for the word requested now.
  assign occupancy = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg);
  assign credit_ok = occupancy < ((CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(pop));
  assign issue     = !sync_rst && clk_en && (redirect || credit_ok);
  assign imem_req  = issue;

  assign out_pc    = entry_pc[rd_ptr_reg];
  assign out_instr = entry_instr[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage: one register pair per entry, written when the write
  // pointer selects it. No reset needed; count gates visibility.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDR_W-1:0]  pc_reg;
      logic [INSTR_W-1:0] instr_reg;

      always_ff @(posedge clk) begin
        if (!sync_rst && clk_en && push && (wr_ptr_reg == PTR_W'(gi))) begin
          pc_reg    <= inflight_pc_reg;
          instr_reg <= imem_rdata;
        end
      end

      assign entry_pc[gi]    = pc_reg;
      assign entry_instr[gi] = instr_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      fetch_pc_reg    <= RESET_VECTOR;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (clk_en) begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= imem_addr;
        fetch_pc_reg    <= imem_addr + ADDR_W'(1);
      end
      if (redirect) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a table of per-cycle vectors (inputs plus
// hand-computed expected outputs) for boot, backpressure and redirect, then
// hand-written sequences for stall, address wrap and reset during a stall.
// Instruction memory is a one-cycle synchronous model whose word is a fixed
// function of its address, so every expected instruction follows from its PC.
module tb_fetch_unit;

  localparam int         ADDR_W = 30;
  localparam int         INSTR_W = 32;
  localparam int         DEPTH = 2;
  localparam logic [29:0] RV = 30'h100;

  logic               clk;
  logic               sync_rst;
  logic               clk_en;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_VECTOR(RV)
  ) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b10, a} ^ 32'h1234_5678;
  endfunction

  // Synchronous instruction memory sharing clk_en; holds data when stalled.
  always @(posedge clk) begin
    if (clk_en && imem_req) imem_rdata <= mem_word(imem_addr);
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        redir;
    logic [29:0] rpc;
    logic        rdy;
    logic        e_req;
    logic        chk_addr;
    logic [29:0] e_addr;
    logic        e_valid;
    logic [29:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic redir,
                              input logic [29:0] rpc, input logic rdy,
                              input logic e_req, input logic chk_addr,
                              input logic [29:0] e_addr, input logic e_valid,
                              input logic [29:0] e_pc);
    vec_t v;
    v.rst = rst; v.en = en; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.chk_addr = chk_addr; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one cycle's inputs just after the clock edge, check at the falling
  // edge, then advance to just after the next rising edge.
  task automatic apply(input vec_t v, input string tag);
    sync_rst    = v.rst;
    clk_en      = v.en;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    out_ready   = v.rdy;
    @(negedge clk);
    check({tag, " imem_req"}, 64'(imem_req), 64'(v.e_req));
    if (v.chk_addr) check({tag, " imem_addr"}, 64'(imem_addr), 64'(v.e_addr));
    check({tag, " out_valid"}, 64'(out_valid), 64'(v.e_valid));
    if (v.e_valid) begin
      check({tag, " out_pc"}, 64'(out_pc), 64'(v.e_pc));
      check({tag, " out_instr"}, 64'(out_instr), 64'(mem_word(v.e_pc)));
    end
    check({tag, " no_overflow"}, 64'(int'(dut.count_reg) <= DEPTH), 64'd1);
    $display("cycle %s: req=%0d addr=%0h valid=%0d pc=%0h", tag, imem_req, imem_addr, out_valid, out_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic add_reset();
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
  endtask

  // Streaming from RESET_VECTOR with out_ready=1: cycle k requests RV+k and
  // shows RV+k-2 at the head from cycle 2.
  task automatic add_boot(input int n);
    for (int k = 0; k < n; k++)
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, RV + 30'(k), k >= 2, RV + 30'(k) - 30'd2));
  endtask

  task automatic run_reset(input string tag);
    apply(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0), {tag, " rst0"});
    apply(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0), {tag, " rst1"});
  endtask

  task automatic run_boot(input int n, input string tag);
    for (int k = 0; k < n; k++)
      apply(mk(0, 1, 0, 0, 1, 1, 1, RV + 30'(k), k >= 2, RV + 30'(k) - 30'd2),
            $sformatf("%s c%0d", tag, k));
  endtask

  initial begin
    sync_rst = 1'b1; clk_en = 1'b1; redirect = 1'b0;
    redirect_pc = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Boot
    add_reset();
    add_boot(6);

    // Backpressure: out_ready=0 during cycles 2..6
    add_reset();
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h100, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h101, 0, 0));
    for (int k = 2; k <= 6; k++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 30'h102, 1, 30'h100));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h102, 1, 30'h100));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h103, 1, 30'h101));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h104, 1, 30'h102));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h105, 1, 30'h103));

    // Redirect at cycle 5 while a valid head is being accepted
    add_reset();
    add_boot(5);
    tbl.push_back(mk(0, 1, 1, 30'h2000, 1, 1, 1, 30'h2000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h2001, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h2002, 1, 30'h2000));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 30'h2003, 1, 30'h2001));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Stall for 3 cycles mid-stream: outputs frozen, pop ignored
    run_reset("stall");
    run_boot(4, "stall");
    for (int k = 4; k <= 6; k++)
      apply(mk(0, 0, 0, 0, 1, 0, 1, 30'h104, 1, 30'h102), $sformatf("stall c%0d", k));
    apply(mk(0, 1, 0, 0, 1, 1, 1, 30'h104, 1, 30'h102), "stall c7");
    apply(mk(0, 1, 0, 0, 1, 1, 1, 30'h105, 1, 30'h103), "stall c8");
    apply(mk(0, 1, 0, 0, 1, 1, 1, 30'h106, 1, 30'h104), "stall c9");

    // Address wrap, fill to DEPTH, then reset while stalled
    run_reset("wrap");
    apply(mk(0, 1, 1, 30'h3FFF_FFFF, 1, 1, 1, 30'h3FFF_FFFF, 0, 0), "wrap c0");
    apply(mk(0, 1, 0, 0, 1, 1, 1, 30'h0, 0, 0), "wrap c1");
    apply(mk(0, 1, 0, 0, 0, 0, 1, 30'h1, 1, 30'h3FFF_FFFF), "wrap c2");
    apply(mk(0, 1, 0, 0, 0, 0, 1, 30'h1, 1, 30'h3FFF_FFFF), "wrap c3");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap c4 rst");
    apply(mk(0, 1, 0, 0, 1, 1, 1, 30'h100, 0, 0), "wrap c5");
    apply(mk(0, 1, 0, 0, 1, 1, 1, 30'h101, 0, 0), "wrap c6");
    apply(mk(0, 1, 0, 0, 1, 1, 1, 30'h102, 1, 30'h100), "wrap c7");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch unit with a prefetch buffer and a valid/ready handshake toward decode. Each cycle it issues at most one word-address request to synchronous instruction memory (one-cycle read latency). It captures returned words with their PC in a DEPTH-entry FIFO and supports same-cycle redirects that flush all queued and in-flight fetches. It sits between the branch/exception redirect logic and the decode stage.

## Interface
- ADDR_W, 30: word-address width (byte address bits [ADDR_W+1:2]).
- INSTR_W, 32: instruction word width.
- DEPTH, 2: prefetch FIFO entries; power of two, ≥2.
- RESET_VECTOR, 0: first word address fetched after reset.

- clk  in  1  clock; all state updates on rising edge.
- sync_rst  in  1  Synchronous, active-high reset; overrides clk_en.
- clk_en  in  1  Global stall; 0 freezes all state. Instruction memory shares clk_en and holds imem_rdata.
- redirect  in  1  Redirect fetch to redirect_pc; flushes FIFO and in-flight request.
- redirect_pc  in  ADDR_W  Redirect target word address.
- imem_req  out  1  Read request this cycle.
- imem_addr  out  ADDR_W  Request word address.
- imem_rdata  in  INSTR_W  Read data, valid the cycle after the accepted request.
- out_valid  out  1  FIFO head valid toward decode.
- out_ready  in  1  Decode accepts head.
- out_pc  out  ADDR_W  Word address of head instruction.
- out_instr  out  INSTR_W  Head instruction word.

## Operation
- State: fetch_pc (next sequential address), inflight bit plus inflight_pc, FIFO of {pc, instr}, count (0..DEPTH).
- Reset: fetch_pc=RESET_VECTOR, inflight=0, count=0, FIFO pointers=0.
- Outputs during reset: imem_req=0, out_valid=0.
- imem_addr = redirect ? redirect_pc : fetch_pc, combinational.
- pop = out_valid & out_ready & clk_en.
- out_valid = (count≠0) & ~redirect & ~sync_rst.
- out_pc and out_instr show the FIFO head.
- Issue condition: sync_rst=0, clk_en=1, and either redirect=1 or count + inflight − pop < DEPTH.
- imem_req is asserted when the issue condition holds.
- On issue: inflight<=1, inflight_pc<=imem_addr, fetch_pc<=imem_addr+1 (modulo 2^ADDR_W; wrap from all-ones to 0).
- No issue: inflight<=0.
- Response: when inflight=1 and redirect=0 (clk_en=1), push {inflight_pc, imem_rdata}.
- Redirect (clk_en=1): count<=0, pointers cleared, the current response is dropped, pop suppressed, and a new request to redirect_pc is issued the same cycle.
- Push and pop in the same cycle: count unchanged.
- Credit rule guarantees no push when full. Overflow is a design error; the bench asserts on it.
- Priority: sync_rst > ~clk_en (hold) > redirect > normal.

## Timing
- Boot: reset released before cycle 0. Cycle 0: imem_req=1, addr=RESET_VECTOR. Cycle 1: data pushed. Cycle 2: out_valid=1.
- Fetch-to-decode latency: 2 cycles (request → visible at head); no bypass.
- Redirect latency: redirect in cycle N → out_valid=1 with out_pc=redirect_pc in cycle N+2.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, requests stop once count+inflight=DEPTH; the FIFO fills to exactly DEPTH; no word is lost or duplicated.
- clk_en=0 in any cycle: no state change, imem_req=0, out_valid unchanged (pop ignored).

## Test plan
- Boot: RESET_VECTOR=0x100, out_ready=1, 6 cycles after reset → imem_addr 0x100,0x101,… from cycle 0; out_pc 0x100 at cycle 2, then +1 per cycle.
- Backpressure: out_ready=0 from cycle 2 for 5 cycles, then 1 → count saturates at DEPTH; imem_req=0 while full; resumed stream continues in contiguous PC order with no gaps or repeats.
- Redirect mid-stream: redirect=1, redirect_pc=0x2000 at cycle 5 → imem_addr=0x2000 at cycle 5; the in-flight word is not delivered; out_pc=0x2000 at cycle 7 with no stale PCs between.
- Redirect with out_ready=1 and valid head in the same cycle → out_valid=0 that cycle; head is discarded, not consumed.
- Stall: clk_en=0 for 3 cycles mid-stream → outputs and state frozen; sequence resumes identically afterwards.
- Wrap plus mid-operation reset: redirect_pc=2^ADDR_W−1 → next fetch 0. sync_rst asserted with count=DEPTH and clk_en=0 → next cycle out_valid=0 and fetch restarts at RESET_VECTOR.
